// File: rtl/reg_bank_param_if.sv
// Bus bundle for reg_bank_param: read request/address, registered read data,
// and the writeback port. The master drives requests, the slave (the bank)
// returns data.
interface reg_bank_param_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) ();
  logic              rd_en;
  logic [ADDR_W-1:0] op1;
  logic [ADDR_W-1:0] op2;
  logic [WIDTH-1:0]  op1_out;
  logic [WIDTH-1:0]  op2_out;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  modport master (
    output rd_en, op1, op2, wr_en, wr_addr, wr_data,
    input  op1_out, op2_out, rd_valid
  );

  modport slave (
    input  rd_en, op1, op2, wr_en, wr_addr, wr_data,
    output op1_out, op2_out, rd_valid
  );
endinterface

// File: rtl/reg_bank_param.sv
// reg_bank_param: DEPTH x WIDTH register bank, two registered read ports and
// one write port. Reads return data one cycle after rd_en with a rd_valid strobe.
// Optional macro REG_BANK_BYPASS_EN: a read that hits the address being written
// at the same edge returns the new data instead of the stored value.
// The bus interface must be instantiated with matching WIDTH and ADDR_W.
module reg_bank_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] op1_out_q, op1_out_d;
  logic [WIDTH-1:0] op2_out_q, op2_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd1_val, rd2_val;

  // Write port: update the addressed register; register 0 is frozen when ZERO_REG is set.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        regs_d[i] = bus.wr_data;
      end
    end
  end

  // Read ports: select stored data, optionally forward same-edge write, force r0 to zero.
  always_comb begin
    rd1_val = regs_q[bus.op1];
    rd2_val = regs_q[bus.op2];
`ifdef REG_BANK_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr == bus.op1)) rd1_val = bus.wr_data;
    if (bus.wr_en && (bus.wr_addr == bus.op2)) rd2_val = bus.wr_data;
`endif
    // The forwarded value must not leak through register 0.
    if ((ZERO_REG != 0) && (bus.op1 == '0)) rd1_val = '0;
    if ((ZERO_REG != 0) && (bus.op2 == '0)) rd2_val = '0;
  end

  // Output next-state: load on rd_en, otherwise hold data and drop the strobe.
  always_comb begin
    op1_out_d  = op1_out_q;
    op2_out_d  = op2_out_q;
    rd_valid_d = 1'b0;
    if (bus.rd_en) begin
      op1_out_d  = rd1_val;
      op2_out_d  = rd2_val;
      rd_valid_d = 1'b1;
    end
  end

  // State registers; reset beats any concurrent read or write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      op1_out_q  <= '0;
      op2_out_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      op1_out_q  <= op1_out_d;
      op2_out_q  <= op2_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.op1_out  = op1_out_q;
  assign bus.op2_out  = op2_out_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param. Two instances:
//   A: WIDTH=16, DEPTH=16, ZERO_REG=1
//   B: WIDTH=32, DEPTH=4,  ZERO_REG=0
// A behavioural model (plain arrays) predicts the outputs after every edge;
// monitors compare on the falling edge.
module tb_reg_bank_param;
  typedef struct packed {
    logic        rd;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        wr;
    logic [3:0]  wa;
    logic [31:0] wd;
  } stim_t;

  typedef struct packed {
    logic        v;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t qa[$];
  exp_t qb[$];

  logic [31:0] mem   [2][16];
  logic [31:0] last1 [2];
  logic [31:0] last2 [2];

  reg_bank_param_if #(.WIDTH(16), .ADDR_W(4)) ifa ();
  reg_bank_param_if #(.WIDTH(32), .ADDR_W(2)) ifb ();

  reg_bank_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  reg_bank_param #(.WIDTH(32), .DEPTH(4), .ZERO_REG(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic rd, input logic [3:0] a1, input logic [3:0] a2,
                               input logic wr, input logic [3:0] wa, input logic [31:0] wd);
    stim_t s;
    s.rd = rd; s.a1 = a1; s.a2 = a2; s.wr = wr; s.wa = wa; s.wd = wd;
    return s;
  endfunction

  // Value a read of address a returns at an edge, given the write issued at that edge.
  function automatic logic [31:0] rdval(input int k, input int a, input stim_t s,
                                        input int zr, input logic [31:0] m, input int dm);
    if (zr != 0 && a == 0) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
    if (s.wr && ((int'(s.wa) & dm) == a)) return s.wd & m;
`endif
    return mem[k][a];
  endfunction

  // Reference model: advance instance k by one edge and queue the expected outputs.
  task automatic model(input int k, input logic r, input stim_t s);
    exp_t        e;
    logic [31:0] m;
    int          zr;
    int          dm;
    int          wa;
    m  = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    zr = (k == 0) ? 1 : 0;
    dm = (k == 0) ? 15 : 3;
    if (r) begin
      for (int i = 0; i < 16; i++) mem[k][i] = 32'h0;
      last1[k] = 32'h0;
      last2[k] = 32'h0;
      e.v = 1'b0;
    end else begin
      if (s.rd) begin
        last1[k] = rdval(k, int'(s.a1) & dm, s, zr, m, dm);
        last2[k] = rdval(k, int'(s.a2) & dm, s, zr, m, dm);
        e.v = 1'b1;
      end else begin
        e.v = 1'b0;
      end
      wa = int'(s.wa) & dm;
      if (s.wr && !(zr != 0 && wa == 0)) mem[k][wa] = s.wd & m;
    end
    e.d1 = last1[k];
    e.d2 = last2[k];
    if (k == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Drive one cycle on both instances, then record the model's predictions.
  task automatic step(input logic r, input stim_t sa, input stim_t sb);
    rst         = r;
    ifa.rd_en   = sa.rd;
    ifa.op1     = sa.a1;
    ifa.op2     = sa.a2;
    ifa.wr_en   = sa.wr;
    ifa.wr_addr = sa.wa;
    ifa.wr_data = sa.wd[15:0];
    ifb.rd_en   = sb.rd;
    ifb.op1     = sb.a1[1:0];
    ifb.op2     = sb.a2[1:0];
    ifb.wr_en   = sb.wr;
    ifb.wr_addr = sb.wa[1:0];
    ifb.wr_data = sb.wd;
    @(posedge clk);
    model(0, r, sa);
    model(1, r, sb);
    #1;
  endtask

  // Monitor A: one comparison set per cycle once predictions are queued.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      exp_t e;
      e = qa.pop_front();
      chk("A_rd_valid", {31'h0, ifa.rd_valid}, {31'h0, e.v});
      chk("A_op1_out", {16'h0, ifa.op1_out}, e.d1);
      chk("A_op2_out", {16'h0, ifa.op2_out}, e.d2);
      if (ifa.rd_valid) $display("A read: op1_out=0x%04h op2_out=0x%04h", ifa.op1_out, ifa.op2_out);
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (qb.size() > 0) begin
      exp_t e;
      e = qb.pop_front();
      chk("B_rd_valid", {31'h0, ifb.rd_valid}, {31'h0, e.v});
      chk("B_op1_out", ifb.op1_out, e.d1);
      chk("B_op2_out", ifb.op2_out, e.d2);
      if (ifb.rd_valid) $display("B read: op1_out=0x%08h op2_out=0x%08h", ifb.op1_out, ifb.op2_out);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t idle;
    stim_t sa;
    stim_t sb;
    logic  r;
    errors = 0;
    checks = 0;
    idle   = mk(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0);

    // Reset, including a read issued under reset.
    step(1'b1, idle, idle);
    step(1'b1, idle, idle);
    step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h5, 32'hBEEF), idle);
    step(1'b1, mk(1'b1, 4'h5, 4'h5, 1'b0, 4'h0, 32'h0), idle);
    step(1'b0, mk(1'b1, 4'h5, 4'h5, 1'b0, 4'h0, 32'h0), idle);

    // Basic write then read, rd_valid for one cycle.
    step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 32'h0008), idle);
    step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h2, 32'h0038), idle);
    step(1'b0, mk(1'b1, 4'h1, 4'h2, 1'b0, 4'h0, 32'h0), idle);
    step(1'b0, idle, idle);

    // Register 0: frozen on A, ordinary on B.
    step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 32'hFFFF),
               mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 32'h0000_FFFF));
    step(1'b0, mk(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0),
               mk(1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0));

    // Same-address collision on both instances, then a follow-up read.
    step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 32'h1111),
               mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 32'h1111));
    step(1'b0, mk(1'b1, 4'h3, 4'h3, 1'b1, 4'h3, 32'h2222),
               mk(1'b1, 4'h3, 4'h3, 1'b1, 4'h3, 32'h2222));
    step(1'b0, mk(1'b1, 4'h3, 4'h3, 1'b0, 4'h0, 32'h0),
               mk(1'b1, 4'h3, 4'h3, 1'b0, 4'h0, 32'h0));

    // Wide data on the 32-bit instance, read through port 2.
    step(1'b0, idle, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'h3, 32'hDEAD_BEEF));
    step(1'b0, idle, mk(1'b1, 4'h1, 4'h3, 1'b0, 4'h0, 32'h0));

    // Streaming: preload i*3, sweep eight back-to-back reads, then hold.
    for (int i = 0; i < 8; i++) step(1'b0, mk(1'b0, 4'h0, 4'h0, 1'b1, 4'(i), 32'(i * 3)), idle);
    for (int i = 0; i < 8; i++) step(1'b0, mk(1'b1, 4'(i), 4'(7 - i), 1'b0, 4'h0, 32'h0), idle);
    step(1'b0, idle, idle);
    step(1'b0, idle, idle);

    // Randomised traffic with occasional resets and forced collisions.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      sa = mk($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) sa.wa = sa.a1;
      sb = mk($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              $urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) sb.wa = sb.a2;
      step(r, sa, sb);
    end

    step(1'b0, idle, idle);
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(qa.size() + qb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised two-read/one-write register bank, the successor to the fixed-content operand lookup feeding the datapath ALU. It holds DEPTH writable registers of WIDTH bits and returns two operands one cycle after a read request, with a valid strobe. A write port lets the writeback stage update registers. Same-cycle write-to-read forwarding is available as a compile-time option.

## Interface
- WIDTH, 16, register and data width in bits (≥1)
- DEPTH, 16, number of registers (≥2, power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary
- clk  input  1  single clock; all state changes on posedge clk
- rst  input  1  reset, synchronous, active-high
- rd_en  input  1  read request; samples both read addresses this cycle
- op1  input  ADDR_W  read address, port 1
- op2  input  ADDR_W  read address, port 2
- op1_out  output  WIDTH  registered read data, port 1
- op2_out  output  WIDTH  registered read data, port 2
- rd_valid  output  1  high for one cycle when op1_out/op2_out hold data for the preceding rd_en
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data

## Operation
- Storage: DEPTH x WIDTH flops. No memory macro inference required.
- Reset (rst=1 at posedge): every register cleared to 0; op1_out=0, op2_out=0, rd_valid=0. rst overrides rd_en and wr_en in the same cycle: no write is committed and no read is issued.
- Write: wr_en=1 at posedge writes wr_data to register wr_addr. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: rd_en=1 at posedge loads op1_out with reg[op1] and op2_out with reg[op2], and sets rd_valid=1 for the next cycle.
- rd_en=0: op1_out and op2_out hold their previous values; rd_valid=0.
- ZERO_REG=1: reading address 0 always returns 0.
- op1==op2 is legal; both outputs get the same value.
- Read and write to the same address in the same cycle: behaviour is set by REG_BANK_BYPASS_EN (see Configuration).
- Read and write to different addresses in the same cycle: the read returns stored contents and the write commits normally.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable by a read sampled at edge N+1.
- Read latency: 1 cycle. rd_en sampled at edge N gives op*_out and rd_valid=1 after edge N.
- Back-to-back reads every cycle are supported; rd_valid stays high continuously.
- Reset is asserted mid-stream: the next cycle shows rd_valid=0 and outputs 0, regardless of an outstanding rd_en. The first legal read after reset is sampled on the first edge with rst=0.
- No combinational path from any input to any output.

## Configuration
- Macro: REG_BANK_BYPASS_EN.
- Defined: if rd_en and wr_en are both high at the same edge and op1 (or op2) equals wr_addr, that output loads wr_data (the new value). The exception is ZERO_REG=1 with address 0, which still returns 0.
- Undefined: that output loads the pre-write stored value (read-before-write). The write still commits at the same edge.

## Test plan
- Reset: write 0xBEEF to reg 5, then assert rst for 1 cycle with rd_en=1, op1=5 → outputs 0 and rd_valid=0 the next cycle. The following read of reg 5 returns 0x0000.
- Write/read: write 0x0008 to reg 1 and 0x0038 to reg 2, then rd_en with op1=1, op2=2 → one cycle later op1_out=0x0008, op2_out=0x0038, rd_valid=1 for exactly 1 cycle.
- Zero register (ZERO_REG=1): write 0xFFFF to reg 0, then read op1=0 → 0x0000. With ZERO_REG=0 the same sequence → 0xFFFF.
- Same-address collision: reg 3 holds 0x1111. At one edge, wr_en with addr 3, data 0x2222 and rd_en with op1=op2=3 → both outputs 0x2222 with REG_BANK_BYPASS_EN defined, 0x1111 without. The next read returns 0x2222 in both builds.
- Streaming: rd_en held high for 8 cycles sweeping op1=0..7, with regs preloaded to i*3 → rd_valid high for 8 consecutive cycles with op1_out=0,3,…,21 in order. Outputs hold the last value after rd_en drops.
- Parameters: WIDTH=32, DEPTH=4 → write 0xDEADBEEF to reg 3, read op2=3 → 0xDEADBEEF.
